if_stage: RTL and testbench

Instruction-fetch stage controller for the pipeline CPU. Owns the program-counter register that drives the instruction unit's `PC` input, and selects the next PC from sequential, branch, jump and jump-register sources. Latches the fetched instruction and its PC+1 into the IF/ID pipeline register, with stall and flush control. Sits directly upstream of the instruction unit, taking its `B`, `J` and `instruction` outputs back in, and directly upstream of the decode stage.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 50 +++++
 rtl/if_stage.sv | 73 +++++++
 tb/tb_if_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and widths: instruction/PC widths, NOP encoding and
// the next-PC source enumeration used by the fetch stage.
package cpu_pkg;
  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int JIDX_W  = 26;
  localparam int IMM_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    HOLD = 3'd1,
    BR   = 3'd2,
    JMP  = 3'd3,
    JR   = 3'd4
  } pc_src_t;
endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: branch/jump/jr target generation, priority
// decode of the PC source and the final next-PC mux.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    iu_b,
  input  logic [3:0]         iu_j,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_base,
  input  logic [IMM_W-1:0]   br_off,
  input  logic               jmp,
  input  logic [JIDX_W-1:0]  jmp_idx,
  input  logic               jr,
  input  logic [PC_W-1:0]    jr_word,
  output logic [PC_W-1:0]    next_pc,
  output pc_src_t            pc_src,
  output logic               redirect
);
  logic signed [PC_W-1:0] br_off_ext;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        jmp_tgt;

  assign br_off_ext = {{(PC_W-IMM_W){br_off[IMM_W-1]}}, br_off};
  assign br_tgt     = br_base + PC_W'(br_off_ext);
  assign jmp_tgt    = {iu_j, jmp_idx};

  // A resolved branch outranks a decode-stage stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_src = SEQ;
    if (br_taken)      pc_src = BR;
    else if (stall)    pc_src = HOLD;
    else if (jr)       pc_src = JR;
    else if (jmp)      pc_src = JMP;
  end

  always_comb begin
    next_pc = iu_b;
    case (pc_src)
      BR:      next_pc = br_tgt;
      JR:      next_pc = jr_word;
      JMP:     next_pc = jmp_tgt;
      HOLD:    next_pc = pc;
      default: next_pc = iu_b;
    endcase
  end

  assign redirect = (pc_src == BR) || (pc_src == JR) || (pc_src == JMP);
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC register and the IF/ID pipeline register,
// with stall hold and squash on redirects or external flush.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 30'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_W-1:0]     pc,
  input  logic [PC_W-1:0]     iu_b,
  input  logic [3:0]          iu_j,
  input  logic [INSTR_W-1:0]  iu_instr,
  input  logic                stall,
  input  logic                flush,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_base,
  input  logic [IMM_W-1:0]    br_off,
  input  logic                jmp,
  input  logic [JIDX_W-1:0]   jmp_idx,
  input  logic                jr,
  input  logic [31:0]         jr_tgt,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [PC_W-1:0]     ifid_pc1,
  output logic                ifid_valid,
  output logic                redirect
);
  logic [PC_W-1:0] next_pc;
  pc_src_t         pc_src;
  logic            unused_jr_byte;

  // JR targets are byte addresses; the low two bits carry no word information.
  assign unused_jr_byte = ^jr_tgt[1:0];

  next_pc_sel u_next_pc_sel (
    .pc       (pc),
    .iu_b     (iu_b),
    .iu_j     (iu_j),
    .stall    (stall),
    .br_taken (br_taken),
    .br_base  (br_base),
    .br_off   (br_off),
    .jmp      (jmp),
    .jmp_idx  (jmp_idx),
    .jr       (jr),
    .jr_word  (jr_tgt[31:2]),
    .next_pc  (next_pc),
    .pc_src   (pc_src),
    .redirect (redirect)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  // IF/ID: flush kills regardless of stall; jumps kill the wrong-path fetch behind them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc1   <= '0;
      ifid_valid <= 1'b0;
    end else if (flush || pc_src == BR || pc_src == JR || pc_src == JMP) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc1   <= '0;
      ifid_valid <= 1'b0;
    end else if (pc_src == SEQ) begin
      ifid_instr <= iu_instr;
      ifid_pc1   <= iu_b;
      ifid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural instruction unit plus a reference model whose
// predicted state is queued per cycle and compared after each rising edge.
module tb_if_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
    logic [29:0] pc1;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] pc;
  logic [29:0] iu_b;
  logic [3:0]  iu_j;
  logic [31:0] iu_instr;
  logic        stall, flush, br_taken, jmp, jr;
  logic [29:0] br_base;
  logic [15:0] br_off;
  logic [25:0] jmp_idx;
  logic [31:0] jr_tgt;
  logic [31:0] ifid_instr;
  logic [29:0] ifid_pc1;
  logic        ifid_valid;
  logic        redirect;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t st;

  function automatic logic [31:0] instr_of(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hC0DE_0000;
  endfunction

  assign iu_b     = pc + 30'd1;
  assign iu_j     = pc[29:26];
  assign iu_instr = instr_of(pc);

  if_stage #(.RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .iu_b(iu_b), .iu_j(iu_j), .iu_instr(iu_instr),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_base(br_base),
    .br_off(br_off), .jmp(jmp), .jmp_idx(jmp_idx), .jr(jr), .jr_tgt(jr_tgt),
    .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
    .redirect(redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_ctl();
    stall = 0; flush = 0; br_taken = 0; br_base = '0; br_off = '0;
    jmp = 0; jmp_idx = '0; jr = 0; jr_tgt = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One clock: predict from the model, queue it, clock, pop and compare.
  task automatic step();
    exp_t        e;
    logic [29:0] brt, seq;
    logic        redir_exp;
    #1;
    seq       = st.pc + 30'd1;
    brt       = br_base + {{14{br_off[15]}}, br_off};
    redir_exp = br_taken | (~stall & (jr | jmp));
    checks++;
    if (redirect !== redir_exp) begin
      errors++;
      $display("FAIL redirect: got %b expected %b at pc %h", redirect, redir_exp, st.pc);
    end
    e = st;
    if (br_taken)             e.pc = brt;
    else if (!stall && jr)    e.pc = jr_tgt[31:2];
    else if (!stall && jmp)   e.pc = {st.pc[29:26], jmp_idx};
    else if (stall)           e.pc = st.pc;
    else                      e.pc = seq;
    if (br_taken || flush) begin
      e.instr = 32'h0; e.pc1 = '0; e.valid = 1'b0;
    end else if (stall) begin
      e.instr = st.instr; e.pc1 = st.pc1; e.valid = st.valid;
    end else if (jr || jmp) begin
      e.instr = 32'h0; e.pc1 = '0; e.valid = 1'b0;
    end else begin
      e.instr = instr_of(st.pc); e.pc1 = seq; e.valid = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++; $display("FAIL sb_pc: got %h expected %h", pc, e.pc);
    end
    checks++;
    if (ifid_instr !== e.instr) begin
      errors++; $display("FAIL sb_instr: got %h expected %h", ifid_instr, e.instr);
    end
    checks++;
    if (ifid_pc1 !== e.pc1) begin
      errors++; $display("FAIL sb_pc1: got %h expected %h", ifid_pc1, e.pc1);
    end
    checks++;
    if (ifid_valid !== e.valid) begin
      errors++; $display("FAIL sb_valid: got %b expected %b", ifid_valid, e.valid);
    end
    st = e;
  endtask

  task automatic model_reset();
    st.pc = 30'h0; st.instr = 32'h0; st.pc1 = 30'h0; st.valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_ctl();
    #1 rst = 1;
    #2;
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_instr", ifid_instr, 32'h0);
    chk("reset_pc1", 32'(ifid_pc1), 32'h0);
    chk("reset_valid", 32'(ifid_valid), 32'h0);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    // first edge already happened above: compare directly then resync the model
    chk("first_pc", 32'(pc), 32'h1);
    chk("first_valid", 32'(ifid_valid), 32'h1);
    chk("first_instr", ifid_instr, instr_of(30'h0));
    st.pc = 30'h1; st.instr = instr_of(30'h0); st.pc1 = 30'h1; st.valid = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("seq_pc", 32'(pc), 32'(i));
      chk("seq_pc1", 32'(ifid_pc1), 32'(i));
      chk("seq_valid", 32'(ifid_valid), 32'h1);
    end
  endtask

  task automatic test_stall();
    step();
    chk("pre_stall_pc", 32'(pc), 32'h5);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", 32'(pc), 32'h5);
      chk("stall_pc1", 32'(ifid_pc1), 32'h5);
      chk("stall_instr", ifid_instr, instr_of(30'h4));
    end
    stall = 0;
    step();
    chk("resume_pc", 32'(pc), 32'h6);
    chk("resume_instr", ifid_instr, instr_of(30'h5));
  endtask

  task automatic test_jump();
    jmp = 1; jmp_idx = 26'h10;
    #1 chk("jmp_redirect", 32'(redirect), 32'h1);
    step();
    chk("jmp_pc", 32'(pc), 32'h10);
    chk("jmp_bubble", 32'(ifid_valid), 32'h0);
    clear_ctl();
    step();
    chk("jmp_after_valid", 32'(ifid_valid), 32'h1);
    chk("jmp_after_pc1", 32'(ifid_pc1), 32'h11);
  endtask

  task automatic test_branch();
    br_taken = 1; br_base = 30'h20; br_off = 16'hFFFC;
    stall = 1; jr = 1; jr_tgt = 32'h0000_0800;
    step();
    chk("br_pc", 32'(pc), 32'h1C);
    chk("br_valid", 32'(ifid_valid), 32'h0);
    clear_ctl();
  endtask

  task automatic test_jr();
    jr = 1; jr_tgt = 32'h0000_0103; jmp = 1; jmp_idx = 26'h77;
    step();
    chk("jr_pc", 32'(pc), 32'h40);
    clear_ctl();
  endtask

  task automatic test_flush();
    flush = 1;
    step();
    chk("flush_pc", 32'(pc), 32'h41);
    chk("flush_valid", 32'(ifid_valid), 32'h0);
    clear_ctl();
    step();
  endtask

  task automatic test_rst_mid();
    jmp = 1; jmp_idx = 26'h9;
    step();
    chk("mid_pre_pc", 32'(pc), 32'h9);
    clear_ctl();
    step();
    #3;
    br_taken = 1; br_base = 30'h123;
    rst = 1;
    #1;
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_valid", 32'(ifid_valid), 32'h0);
    model_reset();
    @(posedge clk); #1;
    chk("mid_rst_hold_pc", 32'(pc), 32'h0);
    @(negedge clk);
    rst = 0;
    clear_ctl();
    step();
    chk("mid_release_pc", 32'(pc), 32'h1);
  endtask

  task automatic test_wrap();
    jr = 1; jr_tgt = 32'hFFFF_FFFC;
    step();
    chk("wrap_top_pc", 32'(pc), 32'h3FFF_FFFF);
    clear_ctl();
    step();
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_pc1", 32'(ifid_pc1), 32'h0);
    chk("wrap_instr", ifid_instr, instr_of(30'h3FFF_FFFF));
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch();
    test_jr();
    test_flush();
    test_rst_mid();
    test_wrap();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
